instruction_add_sub_stop: RTL and testbench
===========================================

# instruction_add_sub_stop

Execution slice for the ADD, SUB and STOP opcodes of the stack CPU. The fetch/decode logic presents one decoded instruction per cycle with its two operand words. The block returns a registered 32-bit result plus flags, or latches a sticky halt on STOP. It sits beside the other execution slices and is selected by `opcode` (instruction bits [31:26]).

## Interface
- `WIDTH`, default 32: operand/result width in bits.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `exec_valid`  in  1  the instruction on `opcode`/`op_a`/`op_b` executes this cycle.
- `opcode`  in  6  instruction bits [31:26].
- `op_a`  in  WIDTH  first operand (second-from-top of stack).
- `op_b`  in  WIDTH  second operand (top of stack).
- `done`  out  1  one-cycle pulse: instruction accepted and completed.
- `result`  out  WIDTH  ADD/SUB result; holds its value between operations.
- `result_we`  out  1  pulses with `done` for ADD/SUB only; tells the caller to push `result`.
- `carry`  out  1  ADD carry-out, or SUB borrow (1 when op_a < op_b unsigned); only with `ADDSUB_FLAGS_EN`.
- `overflow`  out  1  signed two's-complement overflow of the last ADD/SUB; only with `ADDSUB_FLAGS_EN`.
- `illegal`  out  1  pulses with `done` when the opcode is not ADD(0), SUB(1) or STOP(28).
- `halted`  out  1  sticky; set by STOP.

## Operation
- ADD (0): `result` ← (op_a + op_b) mod 2^WIDTH; `carry` = bit WIDTH of the sum; `overflow` = operands have the same sign and the result sign differs.
- SUB (1): `result` ← (op_a − op_b) mod 2^WIDTH; `carry` = borrow; `overflow` = operands have different signs and the result sign differs from op_a.
- STOP (28): `halted` ← 1. `result`, `carry` and `overflow` keep their values. `result_we` = 0.
- Any other opcode:
  - `done` = 1, `illegal` = 1, `result_we` = 0.
  - `result`, flags and `halted` are unchanged.
- While `halted` = 1:
  - `exec_valid` is ignored. No `done`, no `result_we`, no register update.
  - Only `rst` clears `halted`.
- `exec_valid` = 0: outputs hold, except the pulses `done`, `result_we` and `illegal`, which return to 0.
- A STOP issued while already halted has no effect.

## Timing
- Latency is 1 cycle. Inputs are sampled at edge N. `done`, `result`, flags and `halted` are valid after edge N.
- `done`, `result_we` and `illegal` are high for exactly one cycle per accepted instruction.
- Throughput is one instruction per cycle. Back-to-back `exec_valid` gives back-to-back `done` pulses.
- There is no stall or backpressure; the caller must not assert `exec_valid` when it cannot take the result.
- When `rst` and `exec_valid` are high on the same edge, reset wins: the instruction is dropped and no `done` follows.
- Reset values: `result` = 0, `done` = 0, `result_we` = 0, `carry` = 0, `overflow` = 0, `illegal` = 0, `halted` = 0.
- A reset asserted mid-stream, or while halted, returns the block to these values on that edge. The block accepts instructions from the next cycle.

## Configuration
- `ADDSUB_FLAGS_EN` defined:
  - `carry` and `overflow` are computed and registered as described above.
- `ADDSUB_FLAGS_EN` undefined:
  - `carry` and `overflow` are tied to constant 0.
  - The adder is WIDTH bits wide with no carry-out register.
  - All other behaviour is identical.

## Structure
- The shared package `cpu_pkg` holds:
  - the opcode width (6);
  - the full opcode constant set: ADD=0, SUB=1, MUL=2, DIV=3, AND=4, OR=5, XOR=6, NOT=7, JMP=8, JIF=9, INC=10, DEC=11, EQ=12, LE=13, LEE=14, GR=15, GRE=16, PUTB=17, PUTW=18, POP=19, SB=20, SW=21, LB=22, LW=23, PUTARA=24, PUTOPA=25, POPARA=26, POPOPA=27, STOP=28, PUTSP=29;
  - a typedef for the WIDTH-bit data word.
- One sub-module, `addsub_core`, is combinational. It takes a, b and sub; it produces sum, carry/borrow and overflow. SUB is computed as a + ~b + 1, and borrow = ~carry-out.
- The top level holds the decode, the halt register and the output registers.

## Test plan
- Reset → all outputs 0. Then ADD with op_a=5, op_b=7 → one cycle later `done`=1, `result_we`=1, `result`=12, `carry`=0.
- ADD with op_a=0xFFFFFFFF, op_b=1 → `result`=0, `carry`=1, `overflow`=0. ADD with op_a=0x7FFFFFFF, op_b=1 → `result`=0x80000000, `overflow`=1.
- SUB with op_a=3, op_b=5 → `result`=0xFFFFFFFE, `carry` (borrow)=1. SUB with op_a=0x80000000, op_b=1 → `result`=0x7FFFFFFF, `overflow`=1.
- STOP → `halted`=1, `result_we`=0, `result` unchanged. A following ADD(1,1) gives no `done` and `result` unchanged. `rst` → `halted`=0.
- Opcode 2 (MUL) → `done`=1, `illegal`=1, `result_we`=0, state unchanged. Back-to-back ADD(1,2) then SUB(9,4) → `result` 3 then 5 on consecutive cycles.
- `rst` and ADD(1,1) on the same edge → no `done`, `result`=0. Build without `ADDSUB_FLAGS_EN`: the carry case above gives `carry`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared stack-CPU definitions: opcode set, opcode width and data word type.
package cpu_pkg;

  localparam int OPC_W  = 6;
  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD    = 6'd0,
    OP_SUB    = 6'd1,
    OP_MUL    = 6'd2,
    OP_DIV    = 6'd3,
    OP_AND    = 6'd4,
    OP_OR     = 6'd5,
    OP_XOR    = 6'd6,
    OP_NOT    = 6'd7,
    OP_JMP    = 6'd8,
    OP_JIF    = 6'd9,
    OP_INC    = 6'd10,
    OP_DEC    = 6'd11,
    OP_EQ     = 6'd12,
    OP_LE     = 6'd13,
    OP_LEE    = 6'd14,
    OP_GR     = 6'd15,
    OP_GRE    = 6'd16,
    OP_PUTB   = 6'd17,
    OP_PUTW   = 6'd18,
    OP_POP    = 6'd19,
    OP_SB     = 6'd20,
    OP_SW     = 6'd21,
    OP_LB     = 6'd22,
    OP_LW     = 6'd23,
    OP_PUTARA = 6'd24,
    OP_PUTOPA = 6'd25,
    OP_POPARA = 6'd26,
    OP_POPOPA = 6'd27,
    OP_STOP   = 6'd28,
    OP_PUTSP  = 6'd29
  } opcode_e;

endpackage

// File: rtl/addsub_core.sv
// Combinational add/subtract; SUB is a + ~b + 1 with borrow = ~carry-out.
// Flag outputs exist only when ADDSUB_FLAGS_EN is defined.
module addsub_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
`ifdef ADDSUB_FLAGS_EN
  output logic             carry,
  output logic             overflow,
`endif
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] w_b;

  assign w_b = sub ? ~b : b;

`ifdef ADDSUB_FLAGS_EN
  logic [WIDTH:0] w_full;

  assign w_full = {1'b0, a} + {1'b0, w_b} + {{WIDTH{1'b0}}, sub};
  assign sum    = w_full[WIDTH-1:0];
  assign carry  = sub ? ~w_full[WIDTH] : w_full[WIDTH];

  // Same-sign inputs to the adder with a flipped result sign.
  assign overflow = (a[WIDTH-1] == w_b[WIDTH-1]) &&
                    (w_full[WIDTH-1] != a[WIDTH-1]);
`else
  assign sum = a + w_b + {{(WIDTH-1){1'b0}}, sub};
`endif

endmodule

// File: rtl/instruction_add_sub_stop.sv
// ADD/SUB/STOP execution slice: decode, sticky halt, registered result.
// Carry/overflow flags are built only when ADDSUB_FLAGS_EN is defined.
module instruction_add_sub_stop
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exec_valid,
  input  logic [OPC_W-1:0] opcode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             result_we,
  output logic             carry,
  output logic             overflow,
  output logic             illegal,
  output logic             halted
);

  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_we;
  logic             r_illegal;
  logic             r_halted;

  logic             w_accept;
  logic             w_is_add;
  logic             w_is_sub;
  logic             w_is_stop;
  logic             w_arith;
  logic [WIDTH-1:0] w_sum;

  assign w_is_add  = opcode == OP_ADD;
  assign w_is_sub  = opcode == OP_SUB;
  assign w_is_stop = opcode == OP_STOP;
  assign w_arith   = w_is_add | w_is_sub;
  assign w_accept  = exec_valid & ~r_halted;

`ifdef ADDSUB_FLAGS_EN
  logic w_carry;
  logic w_ovf;
  logic r_carry;
  logic r_ovf;

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a        (op_a),
    .b        (op_b),
    .sub      (w_is_sub),
    .carry    (w_carry),
    .overflow (w_ovf),
    .sum      (w_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept && w_arith) begin
      r_carry <= w_carry;
      r_ovf   <= w_ovf;
    end
  end

  assign carry    = r_carry;
  assign overflow = r_ovf;
`else
  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a   (op_a),
    .b   (op_b),
    .sub (w_is_sub),
    .sum (w_sum)
  );

  assign carry    = 1'b0;
  assign overflow = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_done    <= 1'b0;
      r_we      <= 1'b0;
      r_illegal <= 1'b0;
      r_result  <= '0;
      r_halted  <= 1'b0;
    end else begin
      r_done    <= w_accept;
      r_we      <= w_accept & w_arith;
      r_illegal <= w_accept & ~(w_arith | w_is_stop);
      if (w_accept && w_arith)
        r_result <= w_sum;
      if (w_accept && w_is_stop)
        r_halted <= 1'b1;
    end
  end

  assign done      = r_done;
  assign result    = r_result;
  assign result_we = r_we;
  assign illegal   = r_illegal;
  assign halted    = r_halted;

endmodule

// File: tb/tb_instruction_add_sub_stop.sv
// Directed bench for instruction_add_sub_stop; flag expectations follow
// ADDSUB_FLAGS_EN the same way the design build does.
module tb_instruction_add_sub_stop;

`ifdef ADDSUB_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        exec_valid;
  logic [5:0]  opcode;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        done;
  logic [31:0] result;
  logic        result_we;
  logic        carry;
  logic        overflow;
  logic        illegal;
  logic        halted;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  instruction_add_sub_stop #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .exec_valid (exec_valid),
    .opcode     (opcode),
    .op_a       (op_a),
    .op_b       (op_b),
    .done       (done),
    .result     (result),
    .result_we  (result_we),
    .carry      (carry),
    .overflow   (overflow),
    .illegal    (illegal),
    .halted     (halted)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic step(input logic r, input logic v, input logic [5:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    rst = r;
    exec_valid = v;
    opcode = op;
    op_a = a;
    op_b = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    exec_valid = 1'b0;
    opcode = '0;
    op_a = '0;
    op_b = '0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_we", result_we, 0);
    chk("rst_carry", carry, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_halted", halted, 0);

    step(0, 1, 6'd0, 32'd5, 32'd7);
    chk("add_done", done, 1);
    chk("add_we", result_we, 1);
    chk("add_result", result, 32'd12);
    chk("add_carry", carry, 0);
    chk("add_illegal", illegal, 0);

    step(0, 0, 6'd0, 32'd99, 32'd99);
    chk("idle_done", done, 0);
    chk("idle_we", result_we, 0);
    chk("idle_result", result, 32'd12);

    step(0, 1, 6'd0, 32'hFFFF_FFFF, 32'd1);
    chk("addc_result", result, 32'd0);
    chk("addc_carry", carry, {31'd0, FL});
    chk("addc_ovf", overflow, 0);

    step(0, 1, 6'd0, 32'h7FFF_FFFF, 32'd1);
    chk("addv_result", result, 32'h8000_0000);
    chk("addv_ovf", overflow, {31'd0, FL});
    chk("addv_carry", carry, 0);

    step(0, 1, 6'd1, 32'd3, 32'd5);
    chk("subb_result", result, 32'hFFFF_FFFE);
    chk("subb_carry", carry, {31'd0, FL});
    chk("subb_ovf", overflow, 0);

    step(0, 1, 6'd1, 32'h8000_0000, 32'd1);
    chk("subv_result", result, 32'h7FFF_FFFF);
    chk("subv_ovf", overflow, {31'd0, FL});
    chk("subv_carry", carry, 0);

    step(0, 1, 6'd2, 32'd9, 32'd9);
    chk("mul_done", done, 1);
    chk("mul_illegal", illegal, 1);
    chk("mul_we", result_we, 0);
    chk("mul_result", result, 32'h7FFF_FFFF);
    chk("mul_ovf", overflow, {31'd0, FL});

    step(0, 1, 6'd0, 32'd1, 32'd2);
    chk("b2b1_done", done, 1);
    chk("b2b1_illegal", illegal, 0);
    chk("b2b1_result", result, 32'd3);
    step(0, 1, 6'd1, 32'd9, 32'd4);
    chk("b2b2_done", done, 1);
    chk("b2b2_we", result_we, 1);
    chk("b2b2_result", result, 32'd5);

    step(0, 1, 6'd28, 32'd7, 32'd7);
    chk("stop_halted", halted, 1);
    chk("stop_done", done, 1);
    chk("stop_we", result_we, 0);
    chk("stop_illegal", illegal, 0);
    chk("stop_result", result, 32'd5);

    step(0, 1, 6'd0, 32'd1, 32'd1);
    chk("halt_done", done, 0);
    chk("halt_we", result_we, 0);
    chk("halt_result", result, 32'd5);
    chk("halt_halted", halted, 1);

    step(0, 1, 6'd28, 32'd0, 32'd0);
    chk("halt_stop_done", done, 0);

    step(1, 1, 6'd0, 32'd1, 32'd1);
    chk("rstx_halted", halted, 0);
    chk("rstx_result", result, 0);
    chk("rstx_done", done, 0);
    step(0, 0, 6'd0, 32'd0, 32'd0);
    chk("rstx_drop_done", done, 0);
    chk("rstx_drop_result", result, 0);

    step(0, 1, 6'd0, 32'd2, 32'd3);
    chk("post_done", done, 1);
    chk("post_result", result, 32'd5);
    step(0, 0, 6'd0, 32'd0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
